spi_word_rx: RTL

- Parametrised SPI slave (mode 0, MSB first) that runs entirely in the system clock domain.
- Oversamples cs/sck/mosi, assembles WORD_WIDTH-bit words, and presents each word with an auto-incrementing address and a one-cycle write strobe.
- Adds MISO readback from a system-side word source, frame-abort detection, and an optional address-header mode.
- Sits between the external SPI host pins and the framebuffer/register write bus.

---
 rtl/spi_word_rx.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_word_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_word_rx
// Purpose  : SPI slave (mode 0, MSB first) that runs entirely in the clk
//            domain. cs/sck/mosi are oversampled through synchroniser flops,
//            received bits are assembled into WORD_WIDTH-bit words, and each
//            word is presented on data/address with a one-cycle write_strobe.
//            The address auto-increments from all ones, so the first word of a
//            frame lands at 0. A system-side word source is shifted out on
//            miso, and a frame that ends mid-word raises frame_error.
// Optional : define SPI_WORD_RX_HEADER_ADDR_EN to treat the first complete
//            word of each frame as an address header (not strobed); the first
//            data word then lands at the header value.
// Ports    : clk, rst           system clock, asynchronous active-high reset
//            cs, sck, mosi      SPI pins (asynchronous to clk)
//            miso               SPI data out, registered
//            tx_data / tx_load  word source for miso / capture pulse
//            data / address     last received word and its address
//            write_strobe       one-cycle pulse, data/address valid
//            frame_error        one-cycle pulse, cs deasserted mid-word
// Revision : 1.0 - initial release
// ============================================================================
module spi_word_rx #(
    parameter int WORD_WIDTH        = 16,
    parameter int ADDRESS_BUS_WIDTH = 12,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cs,
    input  logic                         sck,
    input  logic                         mosi,
    output logic                         miso,
    input  logic [WORD_WIDTH-1:0]        tx_data,
    output logic                         tx_load,
    output logic [WORD_WIDTH-1:0]        data,
    output logic [ADDRESS_BUS_WIDTH:0]   address,
    output logic                         write_strobe,
    output logic                         frame_error
);

    localparam int                 c_CNT_W    = $clog2(WORD_WIDTH);
    localparam int                 c_AW       = ADDRESS_BUS_WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_BIT_MAX  = c_CNT_W'(WORD_WIDTH - 1);
    localparam logic [c_AW-1:0]    c_ADDR_ONES = {c_AW{1'b1}};

    typedef enum logic [1:0] {
        ST_RESYNC = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. cs resets to 0 so that the RESYNC state only
    // leaves once a genuine high level on the pin has been observed.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync   <= '0;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    logic w_cs;
    logic w_sck;
    logic w_mosi;
    logic w_sck_rise;
    logic w_sck_fall;

    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic [WORD_WIDTH-2:0]   r_rx_shift;
    logic [WORD_WIDTH-1:0]   r_tx_shift;
    logic                    r_skip_fall;
    logic                    r_miso;
    logic [WORD_WIDTH-1:0]   r_data;
    logic [c_AW-1:0]         r_address;
    logic                    r_write_strobe;
    logic                    r_tx_load;
    logic                    r_frame_error;

    logic [WORD_WIDTH-1:0]   w_rx_next;
    logic                    w_frame_start;
    logic                    w_word_done;
    logic                    w_is_header;
    logic [c_AW-1:0]         w_hdr_addr;

    assign w_rx_next     = {r_rx_shift, w_mosi};
    assign w_frame_start = (r_state == ST_IDLE) && !w_cs;
    assign w_word_done   = (r_state == ST_ACTIVE) && !w_cs && w_sck_rise
                           && (r_bit_cnt == '0);

`ifdef SPI_WORD_RX_HEADER_ADDR_EN
    // Header-phase flag: cleared at frame start, set once the first word
    // of the frame has been absorbed as the address header.
    localparam int c_EXT_W = (WORD_WIDTH > c_AW) ? WORD_WIDTH : c_AW;

    logic                r_hdr_done;
    logic [c_EXT_W-1:0]  w_word_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr_done <= 1'b0;
        end else if (w_frame_start) begin
            r_hdr_done <= 1'b0;
        end else if (w_word_done) begin
            r_hdr_done <= 1'b1;
        end
    end

    assign w_word_ext  = c_EXT_W'(w_rx_next);
    assign w_is_header = ~r_hdr_done;
    // Pre-decrement so the following increment lands on the header value.
    assign w_hdr_addr  = w_word_ext[c_AW-1:0] - c_AW'(1);
`else
    assign w_is_header = 1'b0;
    assign w_hdr_addr  = c_ADDR_ONES;
`endif

    // ------------------------------------------------------------------
    // Frame state machine and shift datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_RESYNC;
            r_bit_cnt      <= c_BIT_MAX;
            r_rx_shift     <= '0;
            r_tx_shift     <= '0;
            r_skip_fall    <= 1'b0;
            r_miso         <= 1'b0;
            r_data         <= '0;
            r_address      <= c_ADDR_ONES;
            r_write_strobe <= 1'b0;
            r_tx_load      <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_write_strobe <= 1'b0;
            r_tx_load      <= 1'b0;
            r_frame_error  <= 1'b0;

            case (r_state)
                // Wait for cs high so a reset taken mid-frame never yields
                // a partial word; sck edges are ignored meanwhile.
                ST_RESYNC: begin
                    if (w_cs) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (w_frame_start) begin
                        r_state     <= ST_ACTIVE;
                        r_bit_cnt   <= c_BIT_MAX;
                        r_address   <= c_ADDR_ONES;
                        r_tx_shift  <= tx_data;
                        r_tx_load   <= 1'b1;
                        r_miso      <= tx_data[WORD_WIDTH-1];
                        r_skip_fall <= 1'b0;
                    end
                end

                ST_ACTIVE: begin
                    if (w_cs) begin
                        r_state <= ST_IDLE;
                        // Bits already clocked into a word that never
                        // completed: drop them and flag the frame.
                        if (r_bit_cnt != c_BIT_MAX) begin
                            r_frame_error <= 1'b1;
                        end
                    end else if (w_sck_rise) begin
                        r_rx_shift <= w_rx_next[WORD_WIDTH-2:0];
                        if (r_bit_cnt == '0) begin
                            r_bit_cnt   <= c_BIT_MAX;
                            r_tx_shift  <= tx_data;
                            r_tx_load   <= 1'b1;
                            r_skip_fall <= 1'b1;
                            if (w_is_header) begin
                                r_address <= w_hdr_addr;
                            end else begin
                                r_data         <= w_rx_next;
                                r_address      <= r_address + c_AW'(1);
                                r_write_strobe <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt - c_CNT_W'(1);
                        end
                    end else if (w_sck_fall) begin
                        if (r_skip_fall) begin
                            // The shifter was just reloaded: present the new
                            // word's MSB instead of shifting it away.
                            r_skip_fall <= 1'b0;
                            r_miso      <= r_tx_shift[WORD_WIDTH-1];
                        end else begin
                            r_tx_shift <= {r_tx_shift[WORD_WIDTH-2:0], 1'b0};
                            r_miso     <= r_tx_shift[WORD_WIDTH-2];
                        end
                    end
                end

                default: begin
                    r_state <= ST_RESYNC;
                end
            endcase
        end
    end

    assign miso         = r_miso;
    assign data         = r_data;
    assign address      = r_address;
    assign write_strobe = r_write_strobe;
    assign tx_load      = r_tx_load;
    assign frame_error  = r_frame_error;

endmodule
`default_nettype wire
